mux21_8_rr_arb: RTL and testbench
=================================

# mux21_8_rr_arb

Two-to-one merging arbiter for the 8-bit PCIe switching datapath. It drains two per-class/per-destination FIFOs, such as the lane FIFOs fed by the 1x2 demux, into one downstream FIFO. It uses round-robin arbitration with a configurable burst limit, honours downstream almost-full backpressure, and tags each output word with its source lane.

## Interface

Parameters:
- BURST, 4, maximum consecutive pops from one lane while the other lane is eligible; legal range 1..15.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-low reset.
- in0  input  8  read data of FIFO 0; valid the cycle after pop_0.
- in1  input  8  read data of FIFO 1; valid the cycle after pop_1.
- empty0  input  1  FIFO 0 empty flag.
- empty1  input  1  FIFO 1 empty flag.
- almost_full  input  1  downstream FIFO almost-full flag.
- pop_0  output  1  read strobe to FIFO 0.
- pop_1  output  1  read strobe to FIFO 1.
- out  output  8  merged data word.
- valid_out  output  1  out/lane_out hold a new word this cycle (push to downstream).
- lane_out  output  1  source lane of the word on out.

## Operation

- Eligibility: elig0 = ~empty0 & ~almost_full & reset; elig1 likewise.
- State registers: cur (1 bit, lane currently favoured) and cnt (pops in the current run, 0..BURST, width 4).
- Grant, decided combinationally each cycle:
  - Both lanes eligible: grant cur if cnt < BURST, else grant ~cur.
  - One lane eligible: grant that lane, regardless of cnt.
  - Neither eligible: no grant.
- pop_0 = grant to lane 0; pop_1 = grant to lane 1. At most one pop is high per cycle. Pops are Mealy outputs of registered state plus current flags.
- State update on posedge:
  - Pop of lane cur: cnt <= min(cnt+1, BURST); the count saturates.
  - Pop of lane ~cur: cur <= ~cur, cnt <= 1.
  - No pop: cur and cnt hold. Bursts resume where they paused.
- Data pipeline:
  - Stage 1 registers pop_d = pop_0|pop_1 and sel_d = pop_1.
  - Stage 2 registers, when pop_d = 1: out <= sel_d ? in1 : in0; lane_out <= sel_d; valid_out <= 1.
  - Stage 2 when pop_d = 0: valid_out <= 0; out and lane_out hold their last values.
- Backpressure: almost_full suppresses pops in the same cycle. Up to 2 words already in flight still emerge, so the downstream almost_full threshold must leave at least 2 free entries.
- Reset (reset = 0 at a posedge):
  - out = 0, lane_out = 0, valid_out = 0, cur = 0, cnt = 0, pop_d = 0, sel_d = 0.
  - pop_0 and pop_1 are held low throughout any cycle with reset = 0.
- Reset mid-operation: in-flight words are discarded and never appear on valid_out. Arbitration restarts favouring lane 0.

## Timing

- Pop in cycle N: the FIFO presents data in cycle N+1, captured at the end of N+1. out/valid_out/lane_out are valid in cycle N+2. Latency is 2 cycles from pop.
- Throughput is one word per cycle when any lane is eligible; there are no bubbles on lane switches.
- An empty flag rising at the edge after the last pop stops pops in the next cycle. No over-read is permitted.
- Simultaneous switch and saturation: with cnt = BURST and only cur eligible, pops of cur continue and cnt stays at BURST. Once ~cur becomes eligible, the grant switches in that same cycle.
- Deassertion of almost_full enables pops in the same cycle.

## Test plan

- Reset: hold reset = 0 for 3 cycles with empty0 = empty1 = 0 and almost_full = 0 -> pop_0 = pop_1 = 0 every cycle; out = 0x00, valid_out = 0, lane_out = 0.
- Single lane: FIFO 0 holds 0xA1, 0xA2, 0xA3; FIFO 1 is empty -> pop_0 high for 3 consecutive cycles. out = A1, A2, A3 with lane_out = 0, starting 2 cycles after the first pop. valid_out then drops and there is no 4th pop.
- Round-robin, BURST = 4, 10 words per lane -> pop sequence 0000 1111 0000 1111 00 11. All 20 words appear in pop order with the correct lane_out and no gaps.
- Backpressure: almost_full rises mid-burst after 2 lane-0 pops -> pops drop the same cycle. Exactly 2 further valid_out pulses occur. On deassert, 2 more lane-0 pops follow, then the grant switches to lane 1.
- Burst saturation, BURST = 1: FIFO 1 empty, FIFO 0 holds 6 words -> 6 consecutive pop_0. Then FIFO 1 fills with 0x5A, 0x5B while FIFO 0 still holds data -> pops strictly alternate starting with lane 1.
- Reset mid-burst: reset = 0 in the cycle after a pop_1 -> the word at in1 never appears (valid_out stays 0). After reset is released with both lanes non-empty, the first pop is pop_0.

Source files
------------

// File: rtl/mux21_8_rr_arb.sv
// Two-to-one merging arbiter for the 8-bit switching datapath.
// Drains two lane FIFOs into one downstream FIFO. Arbitration is round-robin
// with a burst limit, it respects downstream almost-full, and each merged word
// carries a tag naming its source lane. Pops are Mealy outputs. Data comes out
// two cycles after its pop.
module mux21_8_rr_arb #(
  parameter int BURST = 4            // legal range 1..15
) (
  input  logic       clk,
  input  logic       reset,          // synchronous, active-low
  input  logic [7:0] in0,
  input  logic [7:0] in1,
  input  logic       empty0,
  input  logic       empty1,
  input  logic       almost_full,
  output logic       pop_0,
  output logic       pop_1,
  output logic [7:0] out,
  output logic       valid_out,
  output logic       lane_out
);

  localparam logic [3:0] LP_BURST = 4'(BURST);

  logic       r_cur;       // lane currently favoured
  logic [3:0] r_cnt;       // pops in the current run, saturates at BURST
  logic       r_pop_d;     // stage 1: a pop happened last cycle
  logic       r_sel_d;     // stage 1: which lane was popped
  logic [7:0] r_out;
  logic       r_lane;
  logic       r_valid;

  logic       w_elig0;
  logic       w_elig1;
  logic       w_gnt_vld;
  logic       w_gnt_lane;

  // Folding reset into eligibility keeps both pops low during any reset cycle.
  assign w_elig0 = ~empty0 & ~almost_full & reset;
  assign w_elig1 = ~empty1 & ~almost_full & reset;

  // Grant: when both lanes compete, stay on cur until the burst is used up.
  // A lone eligible lane always wins, so a saturated count costs no bubble.
  always_comb begin
    w_gnt_vld  = 1'b0;
    w_gnt_lane = 1'b0;
    if (w_elig0 && w_elig1) begin
      w_gnt_vld  = 1'b1;
      w_gnt_lane = (r_cnt < LP_BURST) ? r_cur : ~r_cur;
    end else if (w_elig0) begin
      w_gnt_vld  = 1'b1;
      w_gnt_lane = 1'b0;
    end else if (w_elig1) begin
      w_gnt_vld  = 1'b1;
      w_gnt_lane = 1'b1;
    end
  end

  assign pop_0 = w_gnt_vld & ~w_gnt_lane;
  assign pop_1 = w_gnt_vld &  w_gnt_lane;

  // Arbitration state. Idle cycles hold it, so a paused burst resumes its count.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cur <= 1'b0;
      r_cnt <= 4'd0;
    end else if (w_gnt_vld) begin
      if (w_gnt_lane == r_cur) begin
        r_cnt <= (r_cnt >= LP_BURST) ? LP_BURST : r_cnt + 4'd1;
      end else begin
        r_cur <= w_gnt_lane;
        r_cnt <= 4'd1;
      end
    end
  end

  // Stage 1 follows the FIFO read latency. Reset clears it, which drops the in-flight words.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pop_d <= 1'b0;
      r_sel_d <= 1'b0;
    end else begin
      r_pop_d <= pop_0 | pop_1;
      r_sel_d <= pop_1;
    end
  end

  // Stage 2 captures the FIFO read data. Data and tag keep their last values between words.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_out   <= 8'h00;
      r_lane  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= r_pop_d;
      if (r_pop_d) begin
        r_out  <= r_sel_d ? in1 : in0;
        r_lane <= r_sel_d;
      end
    end
  end

  assign out       = r_out;
  assign lane_out  = r_lane;
  assign valid_out = r_valid;

endmodule

// File: tb/tb_mux21_8_rr_arb.sv
// Directed bench for mux21_8_rr_arb. Instance 0 has BURST=4 and instance 1 has BURST=1.
// A cycle table covers reset and a single-lane drain. Behavioural FIFO models
// drive the multi-cycle sequences. Those are compared as per-cycle pop strings,
// valid strings and word lists.
module tb_mux21_8_rr_arb;

  logic       clk;
  logic       rst_s [2];
  logic       e0_s  [2];
  logic       e1_s  [2];
  logic       af_s  [2];
  logic [7:0] in0_s [2];
  logic [7:0] in1_s [2];
  logic       p0_s  [2];
  logic       p1_s  [2];
  logic [7:0] out_s [2];
  logic       vo_s  [2];
  logic       lo_s  [2];

  mux21_8_rr_arb #(.BURST(4)) u_dut4 (
    .clk(clk), .reset(rst_s[0]), .in0(in0_s[0]), .in1(in1_s[0]),
    .empty0(e0_s[0]), .empty1(e1_s[0]), .almost_full(af_s[0]),
    .pop_0(p0_s[0]), .pop_1(p1_s[0]), .out(out_s[0]),
    .valid_out(vo_s[0]), .lane_out(lo_s[0])
  );

  mux21_8_rr_arb #(.BURST(1)) u_dut1 (
    .clk(clk), .reset(rst_s[1]), .in0(in0_s[1]), .in1(in1_s[1]),
    .empty0(e0_s[1]), .empty1(e1_s[1]), .almost_full(af_s[1]),
    .pop_0(p0_s[1]), .pop_1(p1_s[1]), .out(out_s[1]),
    .valid_out(vo_s[1]), .lane_out(lo_s[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       rst;
    logic       e0;
    logic       e1;
    logic [7:0] d0;
    logic       p0;
    logic       p1;
    logic       vo;
    logic       lo;
    logic [7:0] o;
  } vec_t;

  vec_t       tbl [10];
  int         errors = 0;
  int         checks = 0;
  logic [7:0] q0 [$];
  logic [7:0] q1 [$];
  logic [8:0] got [$];
  logic [8:0] exp_q [$];
  string      g_pops;
  string      g_vos;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_s(input string name, input string act, input string exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %s expected %s", name, act, exp);
    end
  endtask

  // Build the expected word list from a hand-written pop string: lane k's n-th pop carries base_k + n.
  task automatic build_exp(input string p, input logic [7:0] b0, input logic [7:0] b1);
    logic [7:0] n0, n1;
    n0 = b0;
    n1 = b1;
    exp_q.delete();
    for (int i = 0; i < p.len(); i++) begin
      if (p[i] == "0") begin
        exp_q.push_back({1'b0, n0});
        n0 = n0 + 8'd1;
      end else if (p[i] == "1") begin
        exp_q.push_back({1'b1, n1});
        n1 = n1 + 8'd1;
      end
    end
  endtask

  task automatic chk_words(input string name);
    int n;
    chk({name, "_count"}, got.size(), exp_q.size());
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s_word%0d", name, i), {23'd0, got[i]}, {23'd0, exp_q[i]});
  endtask

  task automatic prep(input int d);
    in0_s[d] = 8'h00;
    in1_s[d] = 8'h00;
    e0_s[d]  = (q0.size() == 0);
    e1_s[d]  = (q1.size() == 0);
  endtask

  // One character of ctl per cycle: 'r' means reset low, 'a' means almost_full high, '.' means normal.
  // The FIFO models show popped data the cycle after the pop and raise empty after the last pop.
  task automatic run(input int d, input string ctl);
    logic  p0, p1;
    string c;
    for (int i = 0; i < ctl.len(); i++) begin
      rst_s[d] = (ctl[i] != "r");
      af_s[d]  = (ctl[i] == "a");
      @(negedge clk);
      p0 = p0_s[d];
      p1 = p1_s[d];
      c = (p0 && p1) ? "X" : (p0 ? "0" : (p1 ? "1" : "-"));
      g_pops = {g_pops, c};
      c = vo_s[d] ? "1" : "0";
      g_vos = {g_vos, c};
      if (vo_s[d]) got.push_back({lo_s[d], out_s[d]});
      @(posedge clk);
      #1;
      if (p0 && q0.size() > 0) in0_s[d] = q0.pop_front();
      if (p1 && q1.size() > 0) in1_s[d] = q1.pop_front();
      e0_s[d] = (q0.size() == 0);
      e1_s[d] = (q1.size() == 0);
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst_s[d] = 1'b0; e0_s[d] = 1'b1; e1_s[d] = 1'b1; af_s[d] = 1'b0;
      in0_s[d] = 8'h00; in1_s[d] = 8'h00;
    end

    // Field order: rst e0 e1 d0 | pop0 pop1 valid lane out
    tbl[0] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[1] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[2] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[3] = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 8'hA1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 8'hA2, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA1};
    tbl[6] = '{1'b1, 1'b1, 1'b1, 8'hA3, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA2};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 8'hA3, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA3};
    tbl[8] = '{1'b1, 1'b1, 1'b1, 8'hA3, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA3};
    tbl[9] = '{1'b1, 1'b1, 1'b1, 8'hA3, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA3};

    @(posedge clk);
    #1;

    // Reset hold, then drain a three-word FIFO 0 with FIFO 1 empty.
    for (int i = 0; i < 10; i++) begin
      rst_s[0] = tbl[i].rst;
      e0_s[0]  = tbl[i].e0;
      e1_s[0]  = tbl[i].e1;
      in0_s[0] = tbl[i].d0;
      @(negedge clk);
      chk($sformatf("tbl%0d_pop0", i),  {31'd0, p0_s[0]}, {31'd0, tbl[i].p0});
      chk($sformatf("tbl%0d_pop1", i),  {31'd0, p1_s[0]}, {31'd0, tbl[i].p1});
      chk($sformatf("tbl%0d_valid", i), {31'd0, vo_s[0]}, {31'd0, tbl[i].vo});
      chk($sformatf("tbl%0d_lane", i),  {31'd0, lo_s[0]}, {31'd0, tbl[i].lo});
      chk($sformatf("tbl%0d_out", i),   {24'd0, out_s[0]}, {24'd0, tbl[i].o});
      @(posedge clk);
      #1;
    end

    // Round-robin with BURST=4 and 10 words per lane.
    q0.delete(); q1.delete(); got.delete();
    for (int k = 0; k < 10; k++) begin
      q0.push_back(8'(k));
      q1.push_back(8'(8'h10 + k));
    end
    prep(0);
    g_pops = ""; g_vos = "";
    run(0, "rr........................");
    chk_s("rr_pops",  g_pops, "--00001111000011110011----");
    chk_s("rr_valid", g_vos,  "00001111111111111111111100");
    build_exp("--00001111000011110011----", 8'h00, 8'h10);
    chk_words("rr");

    // Backpressure: almost_full rises after two lane-0 pops and is held for 4 cycles.
    q0.delete(); q1.delete(); got.delete();
    for (int k = 0; k < 6; k++) q0.push_back(8'(8'h40 + k));
    for (int k = 0; k < 4; k++) q1.push_back(8'(8'h80 + k));
    prep(0);
    g_pops = ""; g_vos = "";
    run(0, "rr..aaaa............");
    chk_s("bp_pops",  g_pops, "--00----00111100----");
    chk_s("bp_valid", g_vos,  "00001100001111111100");
    chk_s("bp_inflight", g_vos.substr(4, 7), "1100");
    build_exp("--00----00111100----", 8'h40, 8'h80);
    chk_words("bp");

    // BURST=1: six lone lane-0 pops, then lane 1 fills and grants alternate starting with lane 1.
    q0.delete(); q1.delete(); got.delete();
    for (int k = 0; k < 8; k++) q0.push_back(8'(8'h60 + k));
    prep(1);
    g_pops = ""; g_vos = "";
    run(1, "rr......");
    q1.push_back(8'h5A);
    q1.push_back(8'h5B);
    e1_s[1] = 1'b0;
    run(1, "........");
    chk_s("b1_pops",  g_pops, "--0000001010----");
    chk_s("b1_valid", g_vos,  "0000111111111100");
    build_exp("--0000001010----", 8'h60, 8'h5A);
    chk_words("b1");

    // Reset in the cycle after a pop_1 drops that word. Arbitration then restarts on lane 0.
    q0.delete(); q1.delete(); got.delete();
    for (int k = 0; k < 5; k++) q1.push_back(8'(8'h30 + k));
    prep(0);
    g_pops = ""; g_vos = "";
    run(0, "rr.");
    for (int k = 0; k < 5; k++) q0.push_back(8'(8'h20 + k));
    e0_s[0] = 1'b0;
    run(0, "rr............");
    chk_s("rst_pops",  g_pops, "--1--000011110---");
    chk_s("rst_valid", g_vos,  "00000001111111110");
    build_exp("--000011110---", 8'h20, 8'h31);
    chk_words("rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
